// File: rtl/mdu_pkg.sv
// Shared constants for the RV64M multiply/divide unit: funct3 encodings,
// FSM state type, operand widths and the word sign-extension helper.
package mdu_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] x);
    return {{(XLEN-WLEN){x[WLEN-1]}}, x};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// One radix-2 step on the 128-bit working register: shift-add for multiply,
// shift/trial-subtract (restoring) for divide.
import mdu_pkg::*;

module mdu_iter (
  input  logic            i_is_div,
  input  logic [127:0]    i_work,
  input  logic [XLEN-1:0] i_opnd,
  output logic [127:0]    o_work
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;

  assign w_sum    = {1'b0, i_work[127:64]} + {1'b0, i_opnd};
  // The shifted partial remainder can momentarily need 65 bits.
  assign w_rem_sh = i_work[127:63];
  assign w_ge     = (w_rem_sh >= {1'b0, i_opnd});
  assign w_diff   = w_rem_sh[XLEN-1:0] - i_opnd;

  // Select the step for the active operation class.
  always_comb begin
    o_work = i_work;
    if (i_is_div) begin
      if (w_ge) begin
        o_work = {w_diff, i_work[62:0], 1'b1};
      end else begin
        o_work = {w_rem_sh[XLEN-1:0], i_work[62:0], 1'b0};
      end
    end else begin
      if (i_work[0]) begin
        o_work = {w_sum, i_work[63:1]};
      end else begin
        o_work = {1'b0, i_work[127:1]};
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV64M multiply/divide unit with valid/ready on both sides and flush.
// Define MDU_WORD_OPS_EN to honour word_i (MULW/DIVW/DIVUW/REMW/REMUW).
import mdu_pkg::*;

module mdu #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic                  word_i,
  input  logic [DATA_WIDTH-1:0] alu_A_i,
  input  logic [DATA_WIDTH-1:0] alu_B_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o
);

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic            r_word, r_neg, r_valid;
  logic [6:0]      r_cnt;
  logic [127:0]    r_work, w_iter;
  logic [XLEN-1:0] r_opnd, r_result;

  logic            w_word, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
  logic            w_is_div, w_is_rem, w_b_zero, w_ovf, w_fast, w_last;
  logic [2:0]      w_op;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_fast_raw, w_fast_res;
  logic [XLEN-1:0] w_q, w_r, w_dsel, w_dres, w_calc_res;
  logic [127:0]    w_prod;

`ifdef MDU_WORD_OPS_EN
  assign w_word = word_i;
`else
  logic w_unused_word;
  assign w_unused_word = word_i;
  assign w_word        = 1'b0;
`endif

  // Word-mode funct3 001..011 collapse onto MULW.
  assign w_op     = (w_word && !op_i[2]) ? OP_MUL : op_i;
  assign w_is_div = w_op[2];
  assign w_is_rem = w_op[1];
  assign w_a_sgn  = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_sgn  = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);

  assign w_a_ext = w_word ? (w_a_sgn ? sext_word(alu_A_i[31:0]) : {32'd0, alu_A_i[31:0]}) : alu_A_i;
  assign w_b_ext = w_word ? (w_b_sgn ? sext_word(alu_B_i[31:0]) : {32'd0, alu_B_i[31:0]}) : alu_B_i;
  assign w_a_neg = w_a_sgn & w_a_ext[XLEN-1];
  assign w_b_neg = w_b_sgn & w_b_ext[XLEN-1];
  assign w_a_abs = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
  assign w_b_abs = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;
  // Remainder takes the dividend's sign; everything else the operand XOR.
  assign w_neg   = (w_is_div && w_is_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_b_zero   = (w_b_ext == 64'd0);
  assign w_ovf      = w_is_div && !w_op[0] && (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF) &&
                      (w_a_ext == (w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  assign w_fast     = w_is_div && (w_b_zero || w_ovf);
  assign w_fast_raw = w_b_zero ? (w_is_rem ? w_a_ext : 64'hFFFF_FFFF_FFFF_FFFF)
                               : (w_is_rem ? 64'd0   : w_a_ext);
  assign w_fast_res = w_word ? sext_word(w_fast_raw[31:0]) : w_fast_raw;

  mdu_iter u_iter (
    .i_is_div (r_op[2]),
    .i_work   (r_work),
    .i_opnd   (r_opnd),
    .o_work   (w_iter)
  );

  assign w_last = (r_cnt == (r_word ? 7'd31 : 7'd63));
  assign w_prod = r_neg ? (128'd0 - w_iter) : w_iter;
  assign w_q    = r_word ? {32'd0, w_iter[31:0]}  : w_iter[63:0];
  assign w_r    = r_word ? {32'd0, w_iter[95:64]} : w_iter[127:64];
  assign w_dsel = r_op[1] ? w_r : w_q;
  assign w_dres = r_neg ? (64'd0 - w_dsel) : w_dsel;

  // Result assembled on the edge that performs the final iteration.
  always_comb begin
    w_calc_res = w_prod[127:64];
    if (r_op[2]) begin
      w_calc_res = r_word ? sext_word(w_dres[31:0]) : w_dres;
    end else if (r_op == OP_MUL) begin
      w_calc_res = r_word ? sext_word(w_iter[63:32]) : w_prod[63:0];
    end else begin
      w_calc_res = w_prod[127:64];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush outranks every other input.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = valid_i ? (w_fast ? DONE : CALC) : IDLE;
        CALC:    w_state_nxt = w_last ? DONE : CALC;
        DONE:    w_state_nxt = ready_i ? IDLE : DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result/valid registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_op     <= 3'd0;
      r_word   <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= 7'd0;
      r_work   <= 128'd0;
      r_opnd   <= 64'd0;
      r_result <= 64'd0;
      r_valid  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_op   <= w_op;
            r_word <= w_word;
            r_neg  <= w_neg;
            r_cnt  <= 7'd0;
            r_opnd <= w_is_div ? w_b_abs : w_a_abs;
            r_work <= (w_is_div && w_word) ? {64'd0, w_a_abs[31:0], 32'd0}
                                           : {64'd0, (w_is_div ? w_a_abs : w_b_abs)};
            if (w_fast) begin
              r_result <= w_fast_res;
              r_valid  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_work <= w_iter;
          r_cnt  <= r_cnt + 7'd1;
          if (w_last) begin
            r_result <= w_calc_res;
            r_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign ready_o  = (r_state == IDLE);
  assign busy_o   = (r_state != IDLE);
  assign valid_o  = r_valid;
  assign result_o = r_result;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: directed vectors push expected result/latency,
// a negedge monitor checks each presented result.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = 3'd0;
  logic        word_i = 1'b0;
  logic [63:0] alu_A_i = 64'd0;
  logic [63:0] alu_B_i = 64'd0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [63:0] result_o;
  logic        busy_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic vprev = 1'b0;

  mdu #(.DATA_WIDTH(64)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .word_i   (word_i),
    .alu_A_i  (alu_A_i),
    .alu_B_i  (alu_B_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency on each valid_o rise, value on each accepted result.
  always @(negedge clk) begin
    if (valid_o && !vprev) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
      end
    end
    if (valid_o && ready_i && q.size() != 0) begin
      chk("result", result_o, q[0].res);
      void'(q.pop_front());
    end
    vprev = valid_o;
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ready_o) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input bit push);
    exp_t e;
    wait_idle();
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = op; word_i = w; alu_A_i = a; alu_B_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (push) begin
      e.res = exp; e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst_n_i = 1'b1;

    // Multiply
    issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1);
    issue(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b1);
    issue(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1);
    issue(3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 64, 1'b1);
    issue(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1);
    // Divide
    issue(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b1);
    issue(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1);
    issue(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 64, 1'b1);
    issue(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 64, 1'b1);
    issue(3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b1);
    issue(3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64, 1'b1);
    // Fast path
    issue(3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
    issue(3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 0, 1'b1);
    issue(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1'b1);
    issue(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1'b1);
    // Word ops
`ifdef MDU_WORD_OPS_EN
    issue(3'b101, 1'b1, 64'hFFFF_FFFF_0000_000A, 64'd3, 64'd3, 32, 1'b1);
    issue(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 1'b1);
`else
    issue(3'b101, 1'b1, 64'hFFFF_FFFF_0000_000A, 64'd3, 64'h5555_5555_0000_0003, 64, 1'b1);
    issue(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'h0000_0000_FFFF_FFFE, 64, 1'b1);
`endif

    // Hold in DONE with ready_i low; a second request must not be taken.
    wait_idle();
    ready_i = 1'b0;
    issue(3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 64, 1'b1);
    for (int i = 0; i < 100 && !valid_o; i++) @(negedge clk);
    chk("hold_valid_seen", {63'd0, valid_o}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        valid_i = 1'b1; op_i = 3'b000; alu_A_i = 64'd1; alu_B_i = 64'd1;
      end
      @(negedge clk);
      chk("hold_result", result_o, 64'd15);
      chk("hold_valid", {63'd0, valid_o}, 64'd1);
      chk("hold_ready", {63'd0, ready_o}, 64'd0);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {63'd0, valid_o}, 64'd0);
    chk("release_ready", {63'd0, ready_o}, 64'd1);
    chk("release_busy", {63'd0, busy_o}, 64'd0);

    // Flush at iteration 10 of a divide.
    issue(3'b100, 1'b0, 64'd1000, 64'd3, 64'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", {63'd0, ready_o}, 64'd1);
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    chk("flush_valid", {63'd0, valid_o}, 64'd0);
    repeat (70) @(posedge clk);

    // Flush coincident with a request in IDLE.
    #1 valid_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; alu_A_i = 64'd9; alu_B_i = 64'd0;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_accept_busy", {63'd0, busy_o}, 64'd0);
    repeat (5) @(posedge clk);

    // Reset mid-operation.
    issue(3'b101, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n_i = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, valid_o}, 64'd0);
    chk("midrst_ready", {63'd0, ready_o}, 64'd1);
    chk("midrst_result", result_o, 64'd0);
    @(posedge clk); #1 rst_n_i = 1'b1;
    repeat (70) @(posedge clk);
    issue(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 64, 1'b1);

    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative RV64M multiply/divide unit sitting directly downstream of the execute operand-select stage: it consumes the selected ALU A/B operands when the decoded op is an M-extension instruction and returns a 64-bit result to the writeback path. It uses a radix-2 shift-add multiplier and a restoring divider sharing one 128-bit working register, with a valid/ready handshake on both sides. It also provides a flush input for branch/trap squash.

## Interface
- DATA_WIDTH, 64: operand/result width; only 64 is supported.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept; equals (state == IDLE).
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word_i  in  1  RV64 W-variant request; see Configuration.
- alu_A_i  in  DATA_WIDTH  operand rs1 (dividend / multiplicand).
- alu_B_i  in  DATA_WIDTH  operand rs2 (divisor / multiplier).
- flush_i  in  1  squash any in-flight or pending operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  DATA_WIDTH  registered result.
- busy_o  out  1  state != IDLE; used by hazard logic to stall issue.

## Operation
- States: IDLE, CALC, DONE. Reset: IDLE, valid_o=0, result_o=0, iteration count=0, ready_o=1, busy_o=0.
- IDLE: accept on valid_i && ready_o && !flush_i. At acceptance latch op, take |A|,|B| for signed ops (MULH: both; MULHSU: A only; DIV/REM: both), record result sign, clear count, go to CALC.
- Fast path, divide only: if B==0 or (signed and A==most-negative and B==-1), register result at the acceptance edge and go straight to DONE.
  - B==0: DIV/DIVU give all ones; REM/REMU give A.
  - Signed overflow: DIV gives A; REM gives 0.
- CALC: one iteration per edge.
  - Multiply: add multiplicand if LSB set, then shift right one.
  - Divide: shift left, trial-subtract divisor, set quotient bit if non-negative.
  - N=64 iterations (32 for W ops). The edge performing iteration N loads result_o and goes to DONE, applying sign correction (two's-complement negate) on that load.
  - MUL returns product[63:0]; MULH* return product[127:64]. Quotient sign = signA^signB; remainder sign = signA.
- DONE: valid_o=1, result_o stable. When ready_i=1, go to IDLE next edge and drop valid_o. No new acceptance while in DONE.
- flush_i: in any state, next edge goes to IDLE with valid_o=0. result_o keeps its old value. flush_i has priority over a simultaneous valid_i or ready_i.
- Reset mid-operation: immediate return to reset values; no result is produced.

## Timing
- Accept at edge E0. Iterations at E1..EN. valid_o is high after EN: 64 edges for a 64-bit op, 32 for a W op.
- Fast path: valid_o is high after E0, i.e. one cycle.
- Minimum request-to-request spacing: N+2 cycles (accept, N iterations, one DONE cycle with ready_i=1).
- ready_o and busy_o are combinational from state only, with no combinational path from valid_i.

## Configuration
- MDU_WORD_OPS_EN defined: word_i=1 selects MULW/DIVW/DIVUW/REMW/REMUW.
  - Operands are the low 32 bits, sign- or zero-extended per op, with 32 iterations.
  - The result is sign-extended from bit 31.
  - Fast-path checks use 32-bit values.
  - word_i with funct3 001–011 executes as MULW.
- Undefined: the word_i port remains but is ignored; every op is a 64-bit op.

## Structure
- Package mdu_pkg: funct3 op constants, state enum (IDLE/CALC/DONE), XLEN=64, WLEN=32.
- One sub-module, mdu_iter: combinational single-iteration datapath (add-shift or subtract-shift step on the 128-bit working register plus operand register). The top level holds the FSM, counter, sign fixup and handshake.

## Test plan
- MUL 7 × 0xFFFF_FFFF_FFFF_FFFD (−3) → result_o 0xFFFF_FFFF_FFFF_FFEB, valid_o high 64 cycles after accept; MULHU of all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 → 14, REMU → 2.
- DIVU 5/0 → all ones; REM 5/0 → 5; DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000 and REM → 0; each with valid_o one cycle after accept.
- ready_i held low 5 cycles in DONE → result_o and valid_o stable, ready_o=0, a second valid_i is not accepted; ready_i=1 → IDLE next edge.
- flush_i at iteration 10 of a DIV → valid_o never rises, ready_o=1 next cycle; flush_i coincident with valid_i in IDLE → no acceptance.
- With MDU_WORD_OPS_EN: DIVUW 0xFFFF_FFFF_0000_000A / 3 → 3 after 32 iterations; MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE. Without the macro, the same DIVUW stimulus → 0x5555_5555_0000_0003 after 64 iterations.
